rtp_audio_packer: RTL and testbench
===================================

RTP_AUDIO_PACKER -- requirements
Module: rtp_audio_packer

Interface
REQ-001 Parameter NCH, default 2, meaning audio channels per frame (1..8).
REQ-002 Parameter SW, default 16, meaning bits per sample (8, 16 or 24).
REQ-003 Parameter SPP, default 240, meaning frames per packet (1..1024).
REQ-004 Parameter RTP_HDR, default 16'h8080, meaning RTP bytes 0-1 (V/P/X/CC/M/PT).
REQ-005 Parameter SSRC, default 32'h12345678, meaning RTP bytes 8-11.
REQ-006 Signal list, one per line:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  one-cycle strobe; in_data holds one frame.
- in_data  in  NCH*SW  frame; channel 0 in the MSBs.
- m_data  out  8  packet byte stream.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts the byte.
- m_last  out  1  final byte of packet.
- pkt_len  out  16  constant 12 + NCH*(SW/8)*SPP.
- drop_cnt  out  16  frames dropped, saturating.
- seq_num  out  16  sequence number of the next packet to emit.

Function
REQ-007 Storage: two banks (ping-pong), each SPP frames; one bank is the write bank, the other is the read bank.
REQ-008 On in_valid, the frame is stored at wr_idx of the write bank, and wr_idx increments.
REQ-009 When wr_idx reaches SPP, the write bank is marked full and wr_idx returns to 0.
- If the other bank is free, the banks swap.
- Otherwise the write bank stays full.
REQ-010 While both banks are full, in_valid frames are dropped; drop_cnt increments and saturates at 16'hFFFF.
REQ-011 frame_cnt (32-bit) increments on every in_valid, whether stored or dropped, and wraps at 2^32.
REQ-012 The RTP timestamp of a packet is the frame_cnt value latched when that packet's first frame is stored.
REQ-013 Output FSM states and transitions:
- IDLE -> HDR when a full read bank exists.
- HDR -> PAY after 12 accepted bytes.
- PAY -> IDLE after the last payload byte is accepted.
- Leaving PAY frees the bank.
REQ-014 Header byte order, big-endian:
- bytes 0-1: RTP_HDR
- bytes 2-3: seq_num
- bytes 4-7: timestamp
- bytes 8-11: SSRC
REQ-015 Payload byte order: frame 0 first; within a frame, channel 0 first; within a sample, MSB byte first.
REQ-016 Byte transfer occurs when m_valid and m_ready are both high.
- While m_valid=1 and m_ready=0, m_data and m_last hold stable.
REQ-017 m_valid asserts no later than 2 cycles after the bank-full event.
- With m_ready held high, bytes stream at 1 per cycle with no bubbles.
REQ-018 m_last=1 only on payload byte pkt_len-13 (the final byte).
REQ-019 seq_num increments by 1 when the m_last byte is accepted, and wraps 16'hFFFF -> 0.
REQ-020 Simultaneous events: if the write bank fills in the same cycle the read bank is freed, the swap occurs and no frame is dropped.
REQ-021 Simultaneous events: if a full pending bank exists when PAY completes, the FSM enters HDR without passing an idle gap of more than 1 cycle.

Reset
REQ-022 rst_n=0 sampled at a clk edge clears all state, even mid-packet:
- m_valid=0, m_last=0, m_data=0
- seq_num=0, drop_cnt=0, frame_cnt=0
- wr_idx=0, both banks free, FSM=IDLE
REQ-023 A partially emitted packet is abandoned at reset; no m_last is produced for it.

Verification
REQ-024 Bench configuration: NCH=2, SW=16, SPP=4, so pkt_len=28.
- Stimulus: 4 frames {16'h1111,16'h2222}, {16'h3333,16'h4444}, ..., m_ready=1.
- Required: 28 bytes 80 80 00 00 00 00 00 00 12 34 56 78 11 11 22 22 33 33 44 44 ...; m_last on byte 28; seq_num becomes 1.
REQ-025 Backpressure: m_ready toggles 1010...
- Required: byte sequence identical to REQ-024, and m_data held stable on every stall cycle.
REQ-026 Overflow: m_ready=0, then 12 frames.
- Required: frames 9-12 dropped, drop_cnt=4.
- After m_ready=1: two packets with timestamps 0 and 4; the next stored packet has timestamp 12.
REQ-027 Wrap: preset seq_num to 16'hFFFF by emitting 65535 packets (or via a fast-forward bench option).
- Required: the next packet carries seq bytes FF FF, after which seq_num=0.
REQ-028 Reset mid-packet: assert rst_n=0 at byte 15.
- Required: next cycle m_valid=0; the next packet has seq 00 00 and timestamp 0.
REQ-029 Simultaneous: the 4th frame of a bank arrives in the same cycle the m_last byte is accepted.
- Required: drop_cnt stays 0, and the next packet starts within 2 cycles.

Source files
------------

// File: rtl/rtp_audio_packer.sv
// rtp_audio_packer: ping-pong frame store feeding an
// RTP header + payload byte stream with valid/ready.

module rtp_audio_packer #(
  parameter int          NCH     = 2,
  parameter int          SW      = 16,
  parameter int          SPP     = 240,
  parameter logic [15:0] RTP_HDR = 16'h8080,
  parameter logic [31:0] SSRC    = 32'h12345678,
  parameter logic [15:0] SEQ_RST = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [NCH*SW-1:0] in_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [15:0]       pkt_len,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       seq_num
);

  localparam int FW  = NCH * SW;
  localparam int BPF = FW / 8;
  localparam int IW  = (SPP > 1) ? $clog2(SPP) : 1;
  localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SPP - 1);
  localparam logic [BW-1:0] LAST_BYT = BW'(BPF - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [FW-1:0] r_mem [2][SPP];
  logic          r_wbank;
  logic [IW-1:0] r_widx;
  logic [1:0]    r_full;
  logic [1:0]    w_full_nxt;
  logic [31:0]   r_ts [2];
  logic [31:0]   r_fcnt;
  logic [15:0]   r_drop;
  logic [15:0]   r_seq;
  logic [3:0]    r_hcnt;
  logic [IW-1:0] r_frm;
  logic [BW-1:0] r_byt;

  logic w_rb;
  logic w_xfer;
  logic w_wfull;
  logic w_store;
  logic w_drop;
  logic w_fill;
  logic w_swap;
  logic w_last;
  logic w_free;
  logic w_hdr_end;

  logic [95:0]   w_hdr;
  logic [95:0]   w_hdr_sh;
  logic [FW-1:0] w_frame;
  logic [FW-1:0] w_frm_sh;

  // the read bank is always the one not being written
  assign w_rb      = ~r_wbank;
  assign w_xfer    = m_valid & m_ready;
  assign w_last    = (r_state == S_PAY) &&
                     (r_byt == LAST_BYT) &&
                     (r_frm == LAST_IDX);
  assign w_free    = w_last & w_xfer;
  assign w_hdr_end = (r_state == S_HDR) && w_xfer &&
                     (r_hcnt == 4'd11);
  assign w_wfull   = r_full[r_wbank];
  assign w_store   = in_valid & ~w_wfull;
  assign w_drop    = in_valid & w_wfull;
  assign w_fill    = w_store && (r_widx == LAST_IDX);
  assign w_swap    = (w_fill | w_wfull) &
                     (~r_full[w_rb] | w_free);

  assign pkt_len  = 16'(12 + BPF * SPP);
  assign drop_cnt = r_drop;
  assign seq_num  = r_seq;

  // bank occupancy after this cycle's fill/free events
  always_comb begin
    w_full_nxt = r_full;
    if (w_free) w_full_nxt[w_rb] = 1'b0;
    if (w_fill) w_full_nxt[r_wbank] = 1'b1;
  end

  // sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wbank][r_widx] <= in_data;
  end

  // write side: index, bank flags, swap, counters, timestamps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wbank <= 1'b0;
      r_widx  <= '0;
      r_full  <= 2'b00;
      r_fcnt  <= '0;
      r_drop  <= '0;
      r_ts[0] <= '0;
      r_ts[1] <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (in_valid) r_fcnt <= r_fcnt + 32'd1;
      if (w_drop && r_drop != 16'hFFFF)
        r_drop <= r_drop + 16'd1;
      if (w_store) begin
        r_widx <= w_fill ? '0 : r_widx + 1'b1;
        if (r_widx == '0) r_ts[r_wbank] <= r_fcnt;
      end
      if (w_swap) r_wbank <= ~r_wbank;
    end
  end

  // output FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_hdr    = {RTP_HDR, r_seq, r_ts[w_rb], SSRC};
  assign w_hdr_sh = w_hdr << {r_hcnt, 3'b000};
  assign w_frame  = r_mem[w_rb][r_frm];
  assign w_frm_sh = w_frame << {r_byt, 3'b000};

  // next state and byte-stream outputs
  always_comb begin
    w_state_nxt = r_state;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (r_full[w_rb]) w_state_nxt = S_HDR;
      end
      S_HDR: begin
        m_valid = 1'b1;
        m_data  = w_hdr_sh[95:88];
        if (w_hdr_end) w_state_nxt = S_PAY;
      end
      S_PAY: begin
        m_valid = 1'b1;
        m_last  = w_last;
        m_data  = w_frm_sh[FW-1 -: 8];
        if (w_free) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // byte position within the packet and sequence number
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_frm  <= '0;
      r_byt  <= '0;
      r_seq  <= SEQ_RST;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_hcnt <= '0;
          r_frm  <= '0;
          r_byt  <= '0;
        end
        S_HDR: begin
          if (w_xfer) r_hcnt <= r_hcnt + 4'd1;
        end
        S_PAY: begin
          if (w_xfer) begin
            if (r_byt == LAST_BYT) begin
              r_byt <= '0;
              r_frm <= w_last ? '0 : r_frm + 1'b1;
            end else begin
              r_byt <= r_byt + 1'b1;
            end
          end
          if (w_free) r_seq <= r_seq + 16'd1;
        end
        default: begin
          r_hcnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtp_audio_packer.sv
// tb_rtp_audio_packer: scoreboard bench, NCH=2 SW=16 SPP=4;
// second instance starts seq at FFFF for the wrap case.

module tb_rtp_audio_packer;

  localparam int NCH = 2;
  localparam int SW  = 16;
  localparam int SPP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic [15:0] pkt_len;
  logic [15:0] drop_cnt;
  logic [15:0] seq_num;
  logic [7:0]  w_m_data;
  logic        w_m_valid;
  logic        w_m_last;
  logic [15:0] w_pkt_len;
  logic [15:0] w_drop_cnt;
  logic [15:0] w_seq_num;

  int          nvec = 0;
  int          nerr = 0;
  int          rdy_mode = 0;
  logic [8:0]  q[$];
  logic [8:0]  wcap[$];
  logic [31:0] fbuf[SPP];
  int          nbuf;
  int          pend;
  int          acc;
  logic [31:0] mfcnt;
  logic [31:0] mts;
  logic [15:0] mseq;
  logic [15:0] mdrop;
  logic [95:0] hdr;
  logic [95:0] hsh;
  logic [31:0] fsh;
  logic [8:0]  ex;

  always #5 clk = ~clk;

  rtp_audio_packer #(
    .NCH(NCH), .SW(SW), .SPP(SPP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last),
    .pkt_len(pkt_len), .drop_cnt(drop_cnt),
    .seq_num(seq_num)
  );

  rtp_audio_packer #(
    .NCH(NCH), .SW(SW), .SPP(SPP),
    .SEQ_RST(16'hFFFF)
  ) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .m_data(w_m_data), .m_valid(w_m_valid),
    .m_ready(m_ready), .m_last(w_m_last),
    .pkt_len(w_pkt_len), .drop_cnt(w_drop_cnt),
    .seq_num(w_seq_num)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fr(input int k);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'((2 * k - 1) * 32'h1111);
    b = 16'((2 * k) * 32'h1111);
    return {a, b};
  endfunction

  // downstream ready pattern: low, high or toggling
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ~m_ready;
    endcase
  end

  // reference model and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      wcap.delete();
      nbuf  = 0;
      pend  = 0;
      acc   = 0;
      mfcnt = '0;
      mts   = '0;
      mseq  = '0;
      mdrop = '0;
    end else begin
      if (in_valid) begin
        if (pend == 2) begin
          if (mdrop != 16'hFFFF) mdrop++;
        end else begin
          if (nbuf == 0) mts = mfcnt;
          fbuf[nbuf] = in_data;
          nbuf++;
          if (nbuf == SPP) begin
            hdr = {16'h8080, mseq, mts, 32'h12345678};
            for (int i = 0; i < 12; i++) begin
              hsh = hdr << (8 * i);
              q.push_back({1'b0, hsh[95:88]});
            end
            for (int f = 0; f < SPP; f++) begin
              for (int b = 0; b < 4; b++) begin
                fsh = fbuf[f] << (8 * b);
                q.push_back({(f == SPP - 1 && b == 3),
                             fsh[31:24]});
              end
            end
            mseq++;
            nbuf = 0;
            pend++;
          end
        end
        mfcnt++;
      end
      if (m_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 32'(m_valid), 32'd0);
        end else if (!m_ready) begin
          check("stall_byte", 32'({m_last, m_data}),
                32'(q[0]));
        end else begin
          check("byte", 32'({m_last, m_data}), 32'(q[0]));
          ex = q.pop_front();
          acc++;
          if (ex[8]) begin
            pend--;
            acc = 0;
          end
        end
      end
      if (w_m_valid && m_ready)
        wcap.push_back({w_m_last, w_m_data});
    end
  end

  task automatic frame(input logic [31:0] d);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_seq", 32'(seq_num), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("pkt_len", 32'(pkt_len), 32'd28);
    check("w_pkt_len", 32'(w_pkt_len), 32'd28);
    check("w_rst_drop", 32'(w_drop_cnt), 32'd0);

    // basic packet, ready held high
    rdy_mode = 1;
    for (int k = 1; k <= 4; k++) frame(fr(k));
    idle();
    drain("t1_drain");
    check("t1_seq", 32'(seq_num), 32'd1);
    check("wrap_len", 32'(wcap.size()), 32'd28);
    if (wcap.size() == 28) begin
      check("wrap_b2", 32'(wcap[2]), 32'h0FF);
      check("wrap_b3", 32'(wcap[3]), 32'h0FF);
      check("wrap_last", 32'(wcap[27][8]), 32'd1);
    end
    check("wrap_seq", 32'(w_seq_num), 32'd0);

    // backpressure
    do_reset();
    rdy_mode = 2;
    for (int k = 1; k <= 4; k++) frame(fr(k));
    idle();
    drain("t2_drain");
    rdy_mode = 1;
    check("t2_seq", 32'(seq_num), 32'd1);

    // overflow
    do_reset();
    rdy_mode = 0;
    for (int k = 1; k <= 12; k++) frame(fr(k));
    idle();
    repeat (4) @(posedge clk);
    #1;
    check("t3_drop", 32'(drop_cnt), 32'd4);
    check("t3_pending", 32'(q.size()), 32'd56);
    rdy_mode = 1;
    drain("t3_drain_a");
    for (int k = 13; k <= 16; k++) frame(fr(k));
    idle();
    drain("t3_drain_b");
    check("t3_drop_end", 32'(drop_cnt), 32'd4);
    check("t3_seq", 32'(seq_num), 32'd3);

    // fill coincides with last-byte accept
    do_reset();
    rdy_mode = 1;
    for (int k = 1; k <= 7; k++) frame(fr(k));
    idle();
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(m_valid && m_last) && n < 200);
    check("t4_last_seen", 32'(m_valid & m_last), 32'd1);
    in_valid = 1'b1;
    in_data  = fr(8);
    idle();
    n = 0;
    while (!m_valid && n < 2) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_restart", 32'(m_valid), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd0);
    drain("t4_drain");
    check("t4_seq", 32'(seq_num), 32'd2);

    // reset in the middle of a packet
    do_reset();
    for (int k = 1; k <= 4; k++) frame(fr(k));
    idle();
    n = 0;
    while (acc != 14 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t5_at_byte15", 32'(acc), 32'd14);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid", 32'(m_valid), 32'd0);
    check("t5_last", 32'(m_last), 32'd0);
    check("t5_seq", 32'(seq_num), 32'd0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) frame(fr(k));
    idle();
    drain("t5_drain");
    check("t5_seq_end", 32'(seq_num), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    check("final_queue", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
